// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared constants and helpers for the registered 1-to-N demultiplexer.
//   DEMUX_N_OUT_DEF  : default number of output channels.
//   DEMUX_DATA_W_DEF : default datum / output slice width.
//   demux_sel_width  : select width needed to address a given channel count.
package demux_pkg;

  localparam int DEMUX_N_OUT_DEF  = 2;
  localparam int DEMUX_DATA_W_DEF = 1;

  // Never returns less than 1, so a select port always exists.
  function automatic int demux_sel_width(input int n_out);
    int w;
    w = 1;
    while ((1 << w) < n_out) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : demux_pkg

// File: rtl/demux_sel_dec.sv
// demux_sel_dec
//   Combinational select decoder for the demultiplexer.
//   Turns the select into a one-hot channel mask that is gated by the
//   input qualifier. It also flags an out-of-range select.
//   Ports:
//     s        (in,  SEL_W) : channel select
//     in_valid (in,  1)     : select qualifier
//     onehot   (out, N_OUT) : one-hot channel mask, all zero if invalid/out of range
//     sel_err  (out, 1)     : in_valid with an out-of-range select
module demux_sel_dec
  import demux_pkg::*;
#(
  parameter int N_OUT = DEMUX_N_OUT_DEF,
  parameter int SEL_W = demux_sel_width(N_OUT)
) (
  input  logic [SEL_W-1:0] s,
  input  logic             in_valid,
  output logic [N_OUT-1:0] onehot,
  output logic             sel_err
);

  logic [31:0] s_ext;

  // Widen the select so the range check compares equal widths.
  always_comb begin
    s_ext = 32'(s);
  end

  always_comb begin
    onehot  = '0;
    sel_err = 1'b0;
    if (s_ext < 32'(N_OUT)) begin
      onehot[s] = in_valid;
    end else begin
      sel_err = in_valid;
    end
  end

endmodule : demux_sel_dec

// File: rtl/demux_1to2.sv
// demux_1to2
//   Registered 1-to-N demultiplexer. It routes datum i to output slice s.
//   All unselected slices read zero. Latency is one clock, and the block
//   accepts one datum per clock.
//   Optional feature macro: DEMUX_SEL_ERR_EN. When it is defined, the
//   block gains the registered output sel_err.
//   Ports:
//     clk       (in,  1)            : system clock, rising edge
//     rst_n     (in,  1)            : asynchronous active-low reset
//     s         (in,  SEL_W)        : channel select
//     i         (in,  DATA_W)       : datum to route
//     in_valid  (in,  1)            : datum/select qualifier
//     y         (out, N_OUT*DATA_W) : packed outputs, slice k = y[k*DATA_W +: DATA_W]
//     sel_err   (out, 1)            : out-of-range select seen (DEMUX_SEL_ERR_EN only)
//     out_valid (out, N_OUT)        : per-channel valid, one-hot or zero
module demux_1to2
  import demux_pkg::*;
#(
  parameter int N_OUT  = DEMUX_N_OUT_DEF,
  parameter int DATA_W = DEMUX_DATA_W_DEF,
  parameter int SEL_W  = demux_sel_width(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        s,
  input  logic [DATA_W-1:0]       i,
  input  logic                    in_valid,
  output logic [N_OUT*DATA_W-1:0] y,
`ifdef DEMUX_SEL_ERR_EN
  output logic                    sel_err,
`endif
  output logic [N_OUT-1:0]        out_valid
);

  logic [N_OUT-1:0]        onehot;
  logic                    sel_err_w;
  logic [N_OUT*DATA_W-1:0] y_d, y_q;
  logic [N_OUT-1:0]        out_valid_d, out_valid_q;

  demux_sel_dec #(
    .N_OUT(N_OUT),
    .SEL_W(SEL_W)
  ) u_sel_dec (
    .s        (s),
    .in_valid (in_valid),
    .onehot   (onehot),
    .sel_err  (sel_err_w)
  );

  // Replicate the datum into every slice, then mask it with the decoded
  // channel. The decoder already folds in in_valid and the range check,
  // so an invalid cycle clears every slice.
  always_comb begin
    y_d         = '0;
    out_valid_d = onehot;
    for (int k = 0; k < N_OUT; k++) begin
      y_d[k*DATA_W +: DATA_W] = onehot[k] ? i : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      out_valid_q <= '0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;

`ifdef DEMUX_SEL_ERR_EN
  logic sel_err_d, sel_err_q;

  always_comb begin
    sel_err_d = sel_err_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  // An out-of-range select is dropped silently, so the error bit goes nowhere.
  logic sel_err_unused;
  assign sel_err_unused = sel_err_w;
`endif

endmodule : demux_1to2

// File: tb/tb_demux_1to2.sv
// tb_demux_1to2
//   Directed, table-driven bench for the registered demultiplexer.
//   It exercises the default 1-to-2 instance and a 1-to-3, 8-bit instance.
module tb_demux_1to2;

  logic        clk;
  logic        rst_n;

  // Default configuration: 2 channels, 1-bit datum.
  logic        s2;
  logic        i2;
  logic        v2;
  logic [1:0]  y2;
  logic [1:0]  ov2;

  // Wide configuration: 3 channels, 8-bit datum.
  logic [1:0]  s3;
  logic [7:0]  i3;
  logic        v3;
  logic [23:0] y3;
  logic [2:0]  ov3;

`ifdef DEMUX_SEL_ERR_EN
  logic        se2;
  logic        se3;
`endif

  int compared;
  int mismatched;

  demux_1to2 dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s2),
    .i         (i2),
    .in_valid  (v2),
    .y         (y2),
`ifdef DEMUX_SEL_ERR_EN
    .sel_err   (se2),
`endif
    .out_valid (ov2)
  );

  demux_1to2 #(
    .N_OUT  (3),
    .DATA_W (8)
  ) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s3),
    .i         (i3),
    .in_valid  (v3),
    .y         (y3),
`ifdef DEMUX_SEL_ERR_EN
    .sel_err   (se3),
`endif
    .out_valid (ov3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       v;
    logic       s;
    logic       i;
    logic [1:0] exp_y;
    logic [1:0] exp_ov;
  } vec2_t;

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic [7:0] i;
    logic [23:0] exp_y;
    logic [2:0] exp_ov;
    logic       exp_err;
  } vec3_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic i);
    v2 = v;
    s2 = s;
    i2 = i;
  endtask

  vec2_t vecs2[$];
  vec3_t vecs3[$];
  logic [1:0] prev_y;
  logic [1:0] prev_ov;

  initial begin
    compared   = 0;
    mismatched = 0;

    // Truth table, then an invalid gap, then back-to-back switching.
    vecs2.push_back('{1'b1, 1'b0, 1'b0, 2'b00, 2'b01});
    vecs2.push_back('{1'b1, 1'b1, 1'b0, 2'b00, 2'b10});
    vecs2.push_back('{1'b1, 1'b0, 1'b1, 2'b01, 2'b01});
    vecs2.push_back('{1'b1, 1'b1, 1'b1, 2'b10, 2'b10});
    vecs2.push_back('{1'b1, 1'b0, 1'b1, 2'b01, 2'b01});
    vecs2.push_back('{1'b0, 1'b0, 1'b1, 2'b00, 2'b00});
    vecs2.push_back('{1'b1, 1'b0, 1'b1, 2'b01, 2'b01});
    vecs2.push_back('{1'b1, 1'b1, 1'b1, 2'b10, 2'b10});
    vecs2.push_back('{1'b1, 1'b0, 1'b1, 2'b01, 2'b01});
    vecs2.push_back('{1'b1, 1'b1, 1'b1, 2'b10, 2'b10});
    vecs2.push_back('{1'b0, 1'b1, 1'b1, 2'b00, 2'b00});

    vecs3.push_back('{1'b1, 2'd2, 8'hA5, 24'hA50000, 3'b100, 1'b0});
    vecs3.push_back('{1'b1, 2'd0, 8'h3C, 24'h00003C, 3'b001, 1'b0});
    vecs3.push_back('{1'b1, 2'd1, 8'hFF, 24'h00FF00, 3'b010, 1'b0});
    vecs3.push_back('{1'b1, 2'd3, 8'hA5, 24'h000000, 3'b000, 1'b1});
    vecs3.push_back('{1'b1, 2'd1, 8'h00, 24'h000000, 3'b010, 1'b0});
    vecs3.push_back('{1'b0, 2'd3, 8'h5A, 24'h000000, 3'b000, 1'b0});
    vecs3.push_back('{1'b1, 2'd2, 8'h00, 24'h000000, 3'b100, 1'b0});

    // Hold reset with live inputs and a running clock.
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    v3 = 1'b1;
    s3 = 2'd2;
    i3 = 8'hA5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("reset_y", 32'(y2), 32'h0);
      checkOutput("reset_ov", 32'(ov2), 32'h0);
      checkOutput("reset_y3", 32'(y3), 32'h0);
    end

    // Release reset. The first edge must capture the inputs.
    v3 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_y", 32'(y2), 32'h2);
    checkOutput("release_ov", 32'(ov2), 32'h2);
    prev_y  = 2'b10;
    prev_ov = 2'b10;

    // Default-configuration vector table. Before each edge the outputs must
    // still hold the previous result, which proves the one-cycle latency.
    for (int k = 0; k < vecs2.size(); k++) begin
      @(negedge clk);
      applyStimulus(vecs2[k].v, vecs2[k].s, vecs2[k].i);
      #1;
      checkOutput($sformatf("hold_y[%0d]", k), 32'(y2), 32'(prev_y));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec_y[%0d]", k), 32'(y2), 32'(vecs2[k].exp_y));
      checkOutput($sformatf("vec_ov[%0d]", k), 32'(ov2), 32'(vecs2[k].exp_ov));
      prev_y  = vecs2[k].exp_y;
      prev_ov = vecs2[k].exp_ov;
    end

    // Assert reset mid-cycle with a datum in flight. The outputs must
    // clear before the next edge.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("pre_midreset_y", 32'(y2), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_y", 32'(y2), 32'h0);
    checkOutput("midreset_ov", 32'(ov2), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("midreset_hold_y", 32'(y2), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Wide configuration, including the out-of-range select.
    for (int k = 0; k < vecs3.size(); k++) begin
      @(negedge clk);
      v3 = vecs3[k].v;
      s3 = vecs3[k].s;
      i3 = vecs3[k].i;
      @(posedge clk);
      #1;
      checkOutput($sformatf("w_y[%0d]", k), 32'(y3), 32'(vecs3[k].exp_y));
      checkOutput($sformatf("w_ov[%0d]", k), 32'(ov3), 32'(vecs3[k].exp_ov));
`ifdef DEMUX_SEL_ERR_EN
      checkOutput($sformatf("w_err[%0d]", k), 32'(se3), 32'(vecs3[k].exp_err));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_demux_1to2

// File: doc/demux_1to2.md
Name: demux_1to2

Overview:
- Registered 1-to-N demultiplexer; default configuration is 1-to-2 with a 1-bit datum.
- Routes input datum `i` to the output slice selected by `s`; all unselected slices are driven to zero.
- Used as a leaf routing element wherever one source fans out to one of several sinks.
- Outputs are registered for timing closure between blocks.

Parameters:
- N_OUT, 2, number of output channels (must be >= 2).
- DATA_W, 1, width of the datum and of each output slice.
- SEL_W, $clog2(N_OUT), select width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s  input  SEL_W  channel select.
- i  input  DATA_W  datum to route.
- in_valid  input  1  datum/select qualifier.
- y  output  N_OUT*DATA_W  packed outputs; slice k = y[k*DATA_W +: DATA_W].
- out_valid  output  N_OUT  per-channel valid, one-hot or zero.

Behaviour:
- Reset: asserting rst_n low immediately and asynchronously forces y = 0 and out_valid = 0, regardless of clk.
- Reset release: the block captures inputs on the first rising clk edge after rst_n goes high.
- Each rising edge with in_valid = 1 and s < N_OUT:
  - slice s of y <= i; all other slices <= 0;
  - out_valid <= one-hot(s).
- Each rising edge with in_valid = 0: y <= 0, out_valid <= 0. The block holds no stale data.
- Out-of-range select (s >= N_OUT, possible only when N_OUT is not a power of 2): treated as invalid; y <= 0, out_valid <= 0.
- Latency: exactly 1 clock from input to y/out_valid. Throughput: one datum per clock.
- No back-pressure and no internal state beyond the output registers.
- A value of i = 0 routed to slice s still asserts out_valid[s]; the valid bit, not the data, marks the selected channel.
- Reset asserted mid-stream discards the in-flight datum.
- Default config truth table (in_valid = 1, output one cycle later):
  - s=0, i=0 -> y=2'b00.
  - s=1, i=0 -> y=2'b00.
  - s=0, i=1 -> y=2'b01.
  - s=1, i=1 -> y=2'b10.

Optional Feature:
- Macro: DEMUX_SEL_ERR_EN.
- Defined: adds output sel_err (1 bit, registered, reset value 0).
  - Asserts for one cycle when in_valid = 1 and s >= N_OUT; cleared on the next edge otherwise.
  - y/out_valid behaviour is unchanged.
- Undefined: no sel_err port; an out-of-range select is silently dropped.

Decomposition:
- Package demux_pkg holds the default-width constants (DEMUX_N_OUT_DEF = 2, DEMUX_DATA_W_DEF = 1) and a function computing select width from channel count.
- One sub-module, demux_sel_dec:
  - combinational SEL_W-to-N_OUT one-hot decoder gated by in_valid;
  - outputs all-zero when s is out of range;
  - also produces the range-error bit consumed when DEMUX_SEL_ERR_EN is defined.
- The top level instantiates the decoder, then masks and replicates i into the output registers.

Test Plan:
- Reset: hold rst_n = 0 with in_valid = 1, i = 1, s = 1 and clocks running -> y = 0, out_valid = 0 throughout; assert rst_n low mid-cycle -> outputs clear before the next edge.
- Truth table: in_valid = 1, apply (i,s) = (0,0),(0,1),(1,0),(1,1) on successive edges -> one cycle later y = 00, 00, 01, 10 and out_valid = 01, 10, 01, 10.
- Invalid gap: in_valid toggles 1,0,1 with i = 1, s = 0 -> y = 01, 00, 01, with one-cycle latency.
- Back-to-back switching: s alternating 0/1 every cycle with i = 1 -> y alternates 01/10 with no cycle where both bits are set.
- N_OUT = 3, DATA_W = 8: s = 2, i = 8'hA5 -> y[23:16] = A5 and the other slices 0; s = 3 -> y = 0, out_valid = 0, and sel_err = 1 if DEMUX_SEL_ERR_EN is defined.
